// File: rtl/kernel_bc_fifo_pkg.sv
// Shared types, constants and helpers for the kernel_bc FIFO family.
// Provides clog2, the default counter width and a packed-vector slice helper.
package kernel_bc_fifo_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 2;
   localparam int unsigned CNT_W = DEF_ADDR_WIDTH + 1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

   // LSB of lane idx in a packed vector of w-bit lanes
   function automatic int unsigned slice_lsb(
      input int unsigned idx,
      input int unsigned w
   );
      return idx * w;
   endfunction

endpackage

// File: rtl/kernel_bc_start_bcast_fifo_srl.sv
// Shared DEPTH x DATA_WIDTH shift register with one shift enable.
// Ports: clk, ce (shift), din, addr (NUM_PORTS read addresses), dout (NUM_PORTS async reads).
module kernel_bc_start_bcast_fifo_srl
   import kernel_bc_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned NUM_PORTS  = 2
) (
   input  logic                            clk,
   input  logic                            ce,
   input  logic [DATA_WIDTH-1:0]           din,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] srl_q [DEPTH];
   logic [DATA_WIDTH-1:0] srl_d [DEPTH];

   always_comb begin
      srl_d = srl_q;
      if (ce) begin
         srl_d[0] = din;
         for (int i = 1; i < DEPTH; i++)
            srl_d[i] = srl_q[i-1];
      end
   end

   // Storage is deliberately not reset
   always_ff @(posedge clk) begin
      srl_q <= srl_d;
   end

   always_comb begin
      dout = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++)
         dout[slice_lsb(p, DATA_WIDTH) +: DATA_WIDTH] =
            srl_q[addr[slice_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH]];
   end

endmodule

// File: rtl/kernel_bc_start_bcast_fifo.sv
// Start-token broadcast FIFO: one producer, NUM_CONS independent FWFT consumers.
// Ports: clk, reset (sync, active-high), if_write*/if_din/if_full_n (producer),
// if_read*/if_empty_n/if_dout (per consumer), if_usage (KBC_BCAST_USAGE_EN only).
module kernel_bc_start_bcast_fifo
   import kernel_bc_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned NUM_CONS   = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           if_write_ce,
   input  logic                           if_write,
   input  logic [DATA_WIDTH-1:0]          if_din,
   output logic                           if_full_n,
   input  logic [NUM_CONS-1:0]            if_read_ce,
   input  logic [NUM_CONS-1:0]            if_read,
   output logic [NUM_CONS-1:0]            if_empty_n,
   output logic [NUM_CONS*DATA_WIDTH-1:0] if_dout
`ifdef KBC_BCAST_USAGE_EN
   ,
   output logic [NUM_CONS*(ADDR_WIDTH+1)-1:0] if_usage
`endif
);

   localparam int unsigned CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic                         wr;
   logic [NUM_CONS-1:0]          rd;
   logic [CW-1:0]                cnt_q [NUM_CONS];
   logic [CW-1:0]                cnt_d [NUM_CONS];
   logic [NUM_CONS-1:0]          empty_n_q;
   logic [NUM_CONS-1:0]          empty_n_d;
   logic                         full_n_q;
   logic                         full_n_d;
   logic [NUM_CONS*ADDR_WIDTH-1:0] raddr;

   assign wr = if_write & if_write_ce & full_n_q;
   assign rd = if_read & if_read_ce & empty_n_q;

   always_comb begin
      full_n_d  = 1'b1;
      empty_n_d = '0;
      for (int unsigned k = 0; k < NUM_CONS; k++) begin
         unique case ({wr, rd[k]})
            2'b10:   cnt_d[k] = cnt_q[k] + 1'b1;
            2'b01:   cnt_d[k] = cnt_q[k] - 1'b1;
            default: cnt_d[k] = cnt_q[k];
         endcase
         empty_n_d[k] = (cnt_d[k] != '0);
         // Slowest consumer gates the producer
         if (cnt_d[k] >= DEPTH_C)
            full_n_d = 1'b0;
      end
   end

   // Oldest unread token for consumer k sits at cnt-1
   always_comb begin
      raddr = '0;
      for (int unsigned k = 0; k < NUM_CONS; k++)
         if (cnt_q[k] != '0)
            raddr[slice_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH] =
               ADDR_WIDTH'(cnt_q[k] - 1'b1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '{default: '0};
         empty_n_q <= '0;
         full_n_q  <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         empty_n_q <= empty_n_d;
         full_n_q  <= full_n_d;
      end
   end

   kernel_bc_start_bcast_fifo_srl #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_PORTS  (NUM_CONS)
   ) u_srl (
      .clk  (clk),
      .ce   (wr),
      .din  (if_din),
      .addr (raddr),
      .dout (if_dout)
   );

   assign if_full_n  = full_n_q;
   assign if_empty_n = empty_n_q;

`ifdef KBC_BCAST_USAGE_EN
   always_comb begin
      if_usage = '0;
      for (int unsigned k = 0; k < NUM_CONS; k++)
         if_usage[slice_lsb(k, CW) +: CW] = cnt_q[k];
   end
`endif

endmodule

// File: tb/tb_kernel_bc_start_bcast_fifo.sv
// Scoreboard bench for kernel_bc_start_bcast_fifo.
// Per-consumer token queues model the broadcast FIFO; directed then random traffic.
module tb_kernel_bc_start_bcast_fifo;

   localparam int DW    = 1;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int NC    = 2;
   localparam int CW    = AW + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              if_write_ce = 1'b0;
   logic              if_write = 1'b0;
   logic [DW-1:0]     if_din = '0;
   logic              if_full_n;
   logic [NC-1:0]     if_read_ce = '0;
   logic [NC-1:0]     if_read = '0;
   logic [NC-1:0]     if_empty_n;
   logic [NC*DW-1:0]  if_dout;
`ifdef KBC_BCAST_USAGE_EN
   logic [NC*CW-1:0]  if_usage;
`endif

   kernel_bc_start_bcast_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW),
      .NUM_CONS   (NC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .if_write_ce (if_write_ce),
      .if_write    (if_write),
      .if_din      (if_din),
      .if_full_n   (if_full_n),
      .if_read_ce  (if_read_ce),
      .if_read     (if_read),
      .if_empty_n  (if_empty_n),
      .if_dout     (if_dout)
`ifdef KBC_BCAST_USAGE_EN
      ,
      .if_usage    (if_usage)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Tokens still owed to each consumer, oldest first
   logic [DW-1:0] exp_q [NC][$];

   bit            mon_en = 1'b0;
   bit            pend_rst = 1'b1;
   bit            pend_wr = 1'b0;
   logic [DW-1:0] pend_din = '0;

   function automatic bit model_full();
      for (int k = 0; k < NC; k++)
         if (exp_q[k].size() >= DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
      end
   endtask

   // One clock: commit last edge's outcome to the model, then drive new inputs
   task automatic cyc(input bit w, input bit wce, input logic [DW-1:0] d,
                      input logic [NC-1:0] r, input logic [NC-1:0] rce,
                      input bit rs);
      @(posedge clk);
      #1;
      if (pend_rst) begin
         for (int k = 0; k < NC; k++) exp_q[k].delete();
      end else if (pend_wr) begin
         for (int k = 0; k < NC; k++) exp_q[k].push_back(pend_din);
      end
      pend_rst    = rs;
      pend_wr     = !rs && w && wce && !model_full();
      pend_din    = d;
      reset       = rs;
      if_write    = w;
      if_write_ce = wce;
      if_din      = d;
      if_read     = r;
      if_read_ce  = rce;
      mon_en      = 1'b1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("full_n", 32'(if_full_n), 32'(!model_full()));
         for (int k = 0; k < NC; k++) begin
            check($sformatf("empty_n[%0d]", k), 32'(if_empty_n[k]),
                  32'(exp_q[k].size() != 0));
`ifdef KBC_BCAST_USAGE_EN
            check($sformatf("usage[%0d]", k), 32'(if_usage[k*CW +: CW]),
                  32'(exp_q[k].size()));
`endif
            if (exp_q[k].size() != 0) begin
               check($sformatf("dout[%0d]", k), 32'(if_dout[k*DW +: DW]),
                     32'(exp_q[k][0]));
               if (!reset && if_read[k] && if_read_ce[k])
                  void'(exp_q[k].pop_front());
            end
         end
      end
   end

   initial begin
      // reset
      cyc(0, 0, 0, 2'b00, 2'b00, 1);
      cyc(0, 0, 0, 2'b00, 2'b00, 1);
      // A then B, no reads
      cyc(1, 1, 1'b1, 2'b00, 2'b00, 0);
      cyc(1, 1, 1'b0, 2'b00, 2'b00, 0);
      cyc(0, 0, 0, 2'b00, 2'b00, 0);
      // consumer 0 reads two, consumer 1 idle
      cyc(0, 0, 0, 2'b01, 2'b01, 0);
      cyc(0, 0, 0, 2'b01, 2'b01, 0);
      cyc(0, 0, 0, 2'b00, 2'b00, 0);
      // read on empty consumer 0; write with ce low
      cyc(0, 0, 0, 2'b01, 2'b01, 0);
      cyc(1, 0, 1'b1, 2'b00, 2'b00, 0);
      cyc(0, 0, 0, 2'b00, 2'b00, 0);
      // fill: consumer 0 drains, consumer 1 idle, 5th write rejected
      cyc(0, 0, 0, 2'b00, 2'b00, 1);
      for (int i = 0; i < 5; i++)
         cyc(1, 1, DW'(i), 2'b01, 2'b01, 0);
      cyc(0, 0, 0, 2'b01, 2'b01, 0);
      cyc(0, 0, 0, 2'b10, 2'b10, 0);
      cyc(0, 0, 0, 2'b00, 2'b00, 0);
      cyc(0, 0, 0, 2'b00, 2'b00, 0);
      // write and read together with cnt=2
      cyc(0, 0, 0, 2'b00, 2'b00, 1);
      cyc(1, 1, 1'b1, 2'b00, 2'b00, 0);
      cyc(1, 1, 1'b0, 2'b00, 2'b00, 0);
      cyc(1, 1, 1'b1, 2'b11, 2'b11, 0);
      cyc(0, 0, 0, 2'b00, 2'b00, 0);
      // build cnt={3,1} then reset
      cyc(0, 0, 0, 2'b00, 2'b00, 1);
      cyc(1, 1, 1'b1, 2'b00, 2'b00, 0);
      cyc(1, 1, 1'b0, 2'b10, 2'b10, 0);
      cyc(1, 1, 1'b1, 2'b10, 2'b10, 0);
      cyc(0, 0, 0, 2'b00, 2'b00, 0);
      cyc(0, 0, 0, 2'b00, 2'b00, 1);
      cyc(0, 0, 0, 2'b00, 2'b00, 0);
      // random traffic with occasional reset
      for (int i = 0; i < 800; i++) begin
         cyc($urandom_range(0, 99) < 60,
             $urandom_range(0, 99) < 85,
             DW'($urandom),
             NC'($urandom),
             NC'($urandom | $urandom),
             $urandom_range(0, 79) == 0);
      end
      cyc(0, 0, 0, 2'b00, 2'b00, 0);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
